// File: rtl/nexus_rr_arbiter_16.sv
// nexus_rr_arbiter_16: round-robin burst arbiter with stall watchdog; NEXUS_ARB_STRICT0_EN makes requester 0 strict-priority
module nexus_rr_arbiter_16 #(
  parameter int TIMEOUT = 64,
  parameter int TO_W = $clog2(TIMEOUT + 1)
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [15:0] i_req,
  input  logic [15:0] i_last,
  input  logic        i_ready,
  output logic [15:0] o_gnt,
  output logic [3:0]  o_gnt_idx,
  output logic        o_gnt_valid,
  output logic        o_xfer,
  output logic        o_timeout
);
  typedef enum logic {IDLE, BUSY} state_t;
  state_t state, state_n;
  logic [3:0] ptr, ptr_n, sel_idx, gnt_idx_n;
  logic [15:0] masked, gnt_n;
  logic [TO_W-1:0] wd, wd_n;
  logic busy, wd_hit, rel, load, valid_n;
  function automatic logic [3:0] lowest(input logic [15:0] v);
    lowest = 4'd0;
    for (int i = 15; i >= 0; i--)
      if (v[i]) lowest = 4'(i);
  endfunction
  assign busy = state == BUSY;
  assign o_xfer = o_gnt_valid & i_req[o_gnt_idx] & i_ready;
  assign wd_hit = busy & ~o_xfer & (wd == TO_W'(TIMEOUT - 1));
  assign rel = busy & ((o_xfer & i_last[o_gnt_idx]) | wd_hit);
  assign load = (~busy | rel) & (|i_req);
  assign masked = i_req & ~((16'd1 << ptr_n) - 16'd1);
`ifdef NEXUS_ARB_STRICT0_EN
  assign ptr_n = (rel && o_gnt_idx != 4'd0) ? o_gnt_idx + 4'd1 : ptr;
  assign sel_idx = i_req[0] ? 4'd0 : (|masked) ? lowest(masked) : lowest(i_req);
`else
  assign ptr_n = rel ? o_gnt_idx + 4'd1 : ptr;
  assign sel_idx = (|masked) ? lowest(masked) : lowest(i_req);
`endif
  always_comb begin
    state_n = load ? BUSY : rel ? IDLE : state;
    wd_n = (~busy | load | rel | o_xfer) ? '0 : wd + TO_W'(1);
  end
  always_comb begin
    gnt_n = load ? 16'd1 << sel_idx : rel ? '0 : o_gnt;
    gnt_idx_n = load ? sel_idx : rel ? 4'd0 : o_gnt_idx;
    valid_n = load | (busy & ~rel);
  end
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state <= IDLE;
      ptr <= '0;
      wd <= '0;
      o_gnt <= '0;
      o_gnt_idx <= '0;
      o_gnt_valid <= 1'b0;
      o_timeout <= 1'b0;
    end else begin
      state <= state_n;
      ptr <= ptr_n;
      wd <= wd_n;
      o_gnt <= gnt_n;
      o_gnt_idx <= gnt_idx_n;
      o_gnt_valid <= valid_n;
      o_timeout <= wd_hit;
    end
  end
endmodule

// File: doc/nexus_rr_arbiter_16.md
Name: nexus_rr_arbiter_16

Overview:
- Round-robin burst arbiter that shares one PIFO enqueue port between 16 requesters.
- Grant selection uses two 16-bit low-index-first priority encoders: one on the masked requests, one on the unmasked requests.
- A grant is held for a whole burst, bounded by i_last, with a stall watchdog.
- Sits between the per-flow classifiers and the Nexus PIFO insert datapath; the mux select is driven from o_gnt_idx.

Parameters:
- TIMEOUT, 64: cycles a granted burst may go without a transfer before forced release; legal range 2..1024.
- TO_W, $clog2(TIMEOUT+1): watchdog counter width; derived, do not override.

Ports:
- i_clk  in  1  clock; all logic on rising edge.
- i_rst  in  1  synchronous reset, active-high.
- i_req  in  16  per-requester request; held high for the duration of a burst.
- i_last  in  16  per-requester last-beat flag; sampled only on a transfer beat of the granted requester.
- i_ready  in  1  downstream PIFO port can accept a beat this cycle.
- o_gnt  out  16  one-hot grant, registered.
- o_gnt_idx  out  4  binary index of the granted requester, registered.
- o_gnt_valid  out  1  a grant is active.
- o_xfer  out  1  combinational: o_gnt_valid & i_req[o_gnt_idx] & i_ready. This is the beat-accepted strobe.
- o_timeout  out  1  one-cycle pulse when the watchdog forces a release.

Behaviour:
- Reset values:
  - o_gnt=0, o_gnt_idx=0, o_gnt_valid=0, o_timeout=0.
  - State=IDLE, rr pointer ptr=0, watchdog count=0.
- Reset mid-burst drops the grant on the next edge. No partial-burst bookkeeping is kept.
- Grant selection (ARB logic, combinational):
  - masked = i_req & ~((1<<ptr)-1), i.e. bits with index >= ptr.
  - If masked is nonzero, pick the lowest set index of masked. Otherwise pick the lowest set index of i_req.
  - ptr=0 means the mask covers all 16 bits.
- State IDLE:
  - If i_req != 0: register the selection into o_gnt/o_gnt_idx, set o_gnt_valid=1, go to BUSY, clear the watchdog.
  - Latency: request-to-grant is one cycle.
- State BUSY:
  - o_gnt is stable; other requests are ignored, including a higher-priority requester arriving.
  - On o_xfer & i_last[o_gnt_idx]: release. ptr <= (o_gnt_idx+1) mod 16 (15 wraps to 0). The watchdog clears.
  - Same-cycle rearbitration on release: if any request is pending, excluding the releasing requester only if its i_req is low, the next grant is loaded on the same edge using the updated mask. Back-to-back bursts therefore have zero bubble. Otherwise go to IDLE with o_gnt=0.
  - On o_xfer without last: the watchdog clears.
  - With no o_xfer, the watchdog increments.
  - Granted requester dropping i_req mid-burst: the grant is held. There is no transfer, so the watchdog runs.
- Watchdog:
  - When the count reaches TIMEOUT-1 with no transfer, the next edge force-releases exactly like a last-beat release: ptr advances past the stalled requester.
  - o_timeout=1 for that one cycle.
  - A transfer on the same cycle wins; no timeout is raised.
- i_ready low while granted is a normal stall and counts toward the watchdog.
- i_last of non-granted requesters is don't-care.
- Single requester repeatedly requesting: it is re-granted each release, with no bubble.
- Fairness: with all 16 requesting, grants visit 0..15 in order, then wrap.

Optional Feature:
- Macro: NEXUS_ARB_STRICT0_EN.
- Defined: requester 0 is strict-priority.
  - In IDLE and at a release, if i_req[0]=1, it is granted regardless of ptr.
  - A grant to 0 does not move ptr, so the round-robin order among 1..15 is preserved.
  - It still cannot preempt an active burst.
- Undefined: requester 0 is an ordinary round-robin participant. No extra logic is generated.

Test Plan:
- Reset/idle:
  - Stimulus: assert i_rst for 3 cycles with i_req=16'hFFFF.
  - Response: o_gnt=0, o_gnt_valid=0 throughout. The cycle after i_rst falls, o_gnt=16'h0001 and o_gnt_idx=0.
- Round-robin wrap:
  - Stimulus: i_req=16'h8003, i_ready=1, i_last=16'hFFFF (single-beat bursts).
  - Response: grant sequence 0,1,15,0,1,15 on consecutive cycles, no idle cycle, o_xfer=1 every cycle.
- Burst lock:
  - Stimulus: grant idx 4 with 3-beat burst (i_last[4] on 3rd beat); assert i_req[2] during beat 1; i_ready toggles 1,0,1,1.
  - Response: o_gnt_idx stays 4 for 4 cycles. Next grant is 2 only because no index > 4 is requesting. ptr becomes 5.
- Watchdog:
  - Stimulus: TIMEOUT=8; grant idx 7, then i_ready=0 for 8 cycles, i_req[9]=1.
  - Response: o_timeout pulses once on the 8th stalled cycle's edge. The next cycle o_gnt_idx=9.
- Simultaneous transfer and timeout:
  - Stimulus: o_xfer (non-last) on the exact cycle the count reaches TIMEOUT-1.
  - Response: no o_timeout; the count clears; the grant is held.
- Strict-0 (with NEXUS_ARB_STRICT0_EN):
  - Stimulus: i_req=16'h0031, single-beat.
  - Response: grants 0,0,0 while i_req[0] is held. After i_req[0] drops, grants go 4,5,4,5.
  - Without the macro, the same stimulus gives 0,4,5,0,4,5.
